mem_stage_unit: RTL and testbench

//  Memory stage of the core. Sits between the EX/MEM and MEM/WB boundaries.
//  - Consumes the EX/MEM register outputs.
//  - Runs a req/gnt/rvalid handshake with data memory.
//  - Stalls upstream stages until the access completes.
//  - Registers writeback state (MEM/WB) and drives the forwarding bus back to EX.

---
 rtl/mem_stage_unit.sv | 137 +++++++++++++
 tb/tb_mem_stage_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_unit.sv
// Memory stage: drives the data-memory req/gnt/rvalid handshake, stalls upstream
// until the access completes, and registers MEM/WB state plus the EX forwarding bus.
module mem_stage_unit #(
    parameter int CORE         = 0,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 20,
    parameter int TIMEOUT      = 255
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    mem_load,
    input  logic                    mem_store,
    input  logic                    mem_regWrite,
    input  logic [DATA_WIDTH-1:0]   mem_ALU_result,
    input  logic [DATA_WIDTH-1:0]   mem_store_data,
    input  logic [4:0]              mem_rd,
    output logic                    dmem_req,
    output logic                    dmem_we,
    output logic [ADDRESS_BITS-1:0] dmem_addr,
    output logic [DATA_WIDTH-1:0]   dmem_wdata,
    input  logic                    dmem_gnt,
    input  logic                    dmem_rvalid,
    input  logic [DATA_WIDTH-1:0]   dmem_rdata,
    output logic                    mem_stall,
    output logic                    wb_regWrite,
    output logic [4:0]              wb_rd,
    output logic [DATA_WIDTH-1:0]   wb_write_data,
    output logic                    mem_write,
    output logic [4:0]              mem_write_reg,
    output logic [DATA_WIDTH-1:0]   mem_write_data,
    output logic                    mem_error
);

    localparam int WD_W = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t                  state_q;
    logic [WD_W-1:0]         wd_q;
    logic                    wb_regwrite_q;
    logic [4:0]              wb_rd_q;
    logic [DATA_WIDTH-1:0]   wb_data_q;
    logic                    mem_error_q;

    logic                    access_s;
    logic                    is_store_s;
    logic                    in_wait_s;
    logic                    expire_s;
    logic                    ok_s;
    logic                    forced_s;
    logic                    done_s;
    logic                    rd_nz_s;
    logic                    err_hit_s;
    logic [31:0]             unused_core_s;

    assign unused_core_s = 32'(CORE);

    assign access_s   = mem_load | mem_store;
    // A simultaneous load+store is handled as a load.
    assign is_store_s = mem_store & ~mem_load;
    assign in_wait_s  = (state_q == S_WAIT);
    assign expire_s   = (state_q != S_IDLE) && (wd_q == WD_W'(TIMEOUT - 1));
    assign ok_s       = (~in_wait_s & dmem_gnt & is_store_s) | (in_wait_s & dmem_rvalid);
    assign forced_s   = access_s & expire_s & ~ok_s;
    assign done_s     = access_s & (ok_s | expire_s);
    assign rd_nz_s    = (mem_rd != 5'd0);
    assign err_hit_s  = access_s & (forced_s | (mem_load & mem_store) |
                                    (mem_ALU_result[1:0] != 2'b00));

    assign dmem_req   = access_s & ~in_wait_s & ~reset;
    assign dmem_we    = is_store_s;
    assign dmem_addr  = mem_ALU_result[ADDRESS_BITS+1:2];
    assign dmem_wdata = mem_store_data;
    assign mem_stall  = access_s & ~done_s & ~reset;

    assign wb_regWrite    = wb_regwrite_q;
    assign wb_rd          = wb_rd_q;
    assign wb_write_data  = wb_data_q;
    assign mem_write      = wb_regwrite_q;
    assign mem_write_reg  = wb_rd_q;
    assign mem_write_data = wb_data_q;
    assign mem_error      = mem_error_q;

    // Handshake FSM, watchdog, MEM/WB register and sticky error flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            wd_q          <= {WD_W{1'b0}};
            wb_regwrite_q <= 1'b0;
            wb_rd_q       <= 5'd0;
            wb_data_q     <= {DATA_WIDTH{1'b0}};
            mem_error_q   <= 1'b0;
        end else begin
            if (!access_s || done_s) begin
                state_q <= S_IDLE;
                wd_q    <= {WD_W{1'b0}};
            end else begin
                wd_q <= wd_q + WD_W'(1);
                case (state_q)
                    S_IDLE, S_REQ: state_q <= dmem_gnt ? S_WAIT : S_REQ;
                    S_WAIT:        state_q <= S_WAIT;
                    default:       state_q <= S_IDLE;
                endcase
            end

            if (!access_s) begin
                wb_regwrite_q <= mem_regWrite & rd_nz_s;
                wb_rd_q       <= mem_rd;
                wb_data_q     <= mem_ALU_result;
            end else if (done_s) begin
                wb_rd_q <= mem_rd;
                if (is_store_s) begin
                    wb_regwrite_q <= 1'b0;
                    wb_data_q     <= mem_ALU_result;
                end else begin
                    wb_regwrite_q <= mem_regWrite & rd_nz_s;
                    wb_data_q     <= forced_s ? {DATA_WIDTH{1'b0}} : dmem_rdata;
                end
            end else begin
                wb_regwrite_q <= 1'b0;
                wb_rd_q       <= wb_rd_q;
                wb_data_q     <= wb_data_q;
            end

            if (err_hit_s) begin
                mem_error_q <= 1'b1;
            end else begin
                mem_error_q <= mem_error_q;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_unit.sv
// Directed bench for mem_stage_unit; a second instance with TIMEOUT=4 covers the watchdog.
module tb_mem_stage_unit;

    logic        clock;
    logic        reset;
    logic        mem_load, mem_store, mem_regWrite;
    logic [31:0] mem_ALU_result, mem_store_data;
    logic [4:0]  mem_rd;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;

    logic        dmem_req, dmem_we, mem_stall, wb_regWrite, mem_write, mem_error;
    logic [19:0] dmem_addr;
    logic [31:0] dmem_wdata, wb_write_data, mem_write_data;
    logic [4:0]  wb_rd, mem_write_reg;

    logic        dmem_req_t, dmem_we_t, mem_stall_t, wb_regWrite_t, mem_write_t, mem_error_t;
    logic [19:0] dmem_addr_t;
    logic [31:0] dmem_wdata_t, wb_write_data_t, mem_write_data_t;
    logic [4:0]  wb_rd_t, mem_write_reg_t;

    int checks = 0;
    int errors = 0;

    mem_stage_unit #(.CORE(0), .DATA_WIDTH(32), .ADDRESS_BITS(20), .TIMEOUT(255)) dut (
        .clock(clock), .reset(reset), .mem_load(mem_load), .mem_store(mem_store),
        .mem_regWrite(mem_regWrite), .mem_ALU_result(mem_ALU_result),
        .mem_store_data(mem_store_data), .mem_rd(mem_rd),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .mem_stall(mem_stall), .wb_regWrite(wb_regWrite), .wb_rd(wb_rd),
        .wb_write_data(wb_write_data), .mem_write(mem_write), .mem_write_reg(mem_write_reg),
        .mem_write_data(mem_write_data), .mem_error(mem_error)
    );

    mem_stage_unit #(.CORE(1), .DATA_WIDTH(32), .ADDRESS_BITS(20), .TIMEOUT(4)) dut_t (
        .clock(clock), .reset(reset), .mem_load(mem_load), .mem_store(mem_store),
        .mem_regWrite(mem_regWrite), .mem_ALU_result(mem_ALU_result),
        .mem_store_data(mem_store_data), .mem_rd(mem_rd),
        .dmem_req(dmem_req_t), .dmem_we(dmem_we_t), .dmem_addr(dmem_addr_t),
        .dmem_wdata(dmem_wdata_t), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata), .mem_stall(mem_stall_t), .wb_regWrite(wb_regWrite_t),
        .wb_rd(wb_rd_t), .wb_write_data(wb_write_data_t), .mem_write(mem_write_t),
        .mem_write_reg(mem_write_reg_t), .mem_write_data(mem_write_data_t),
        .mem_error(mem_error_t)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic idle_inputs;
        mem_load = 1'b0; mem_store = 1'b0; mem_regWrite = 1'b0;
        mem_ALU_result = 32'h0; mem_store_data = 32'h0; mem_rd = 5'd0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    endtask

    task automatic next_edge;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        idle_inputs();
        next_edge();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        idle_inputs();
        mem_load = 1'b1;
        mem_ALU_result = 32'h40;
        @(negedge clock);
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", dmem_req); end
        checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", mem_stall); end
        next_edge();
        checks++; if (wb_regWrite !== 1'b0 || wb_rd !== 5'd0 || wb_write_data !== 32'h0) begin
            errors++; $display("FAIL reset_wb: got %b %0d %h want 0 0 0", wb_regWrite, wb_rd, wb_write_data); end
        checks++; if (mem_write !== 1'b0 || mem_error !== 1'b0) begin
            errors++; $display("FAIL reset_fwd_err: got %b %b want 0 0", mem_write, mem_error); end
        idle_inputs();
        reset = 1'b0;
    endtask

    task automatic test_alu;
        mem_regWrite = 1'b1; mem_rd = 5'd5; mem_ALU_result = 32'h1234;
        @(negedge clock);
        checks++; if (mem_stall !== 1'b0 || dmem_req !== 1'b0) begin
            errors++; $display("FAIL alu_stall: got stall=%b req=%b want 0 0", mem_stall, dmem_req); end
        next_edge();
        checks++; if (wb_regWrite !== 1'b1 || wb_rd !== 5'd5 || wb_write_data !== 32'h1234) begin
            errors++; $display("FAIL alu_wb: got %b %0d %h want 1 5 1234", wb_regWrite, wb_rd, wb_write_data); end
        checks++; if (mem_write !== 1'b1 || mem_write_reg !== 5'd5 || mem_write_data !== 32'h1234) begin
            errors++; $display("FAIL alu_fwd: got %b %0d %h want 1 5 1234", mem_write, mem_write_reg, mem_write_data); end
        idle_inputs();
    endtask

    task automatic test_load;
        int stalls = 0;
        mem_load = 1'b1; mem_regWrite = 1'b1; mem_rd = 5'd9; mem_ALU_result = 32'h40;
        for (int c = 0; c < 5; c++) begin
            dmem_gnt = (c == 0);
            dmem_rvalid = (c == 4);
            dmem_rdata = (c == 4) ? 32'hDEADBEEF : 32'h11111111;
            @(negedge clock);
            if (mem_stall === 1'b1) stalls++;
            checks++; if (dmem_req !== (c == 0)) begin
                errors++; $display("FAIL load_req c%0d: got %b want %b", c, dmem_req, (c == 0)); end
            if (c == 0) begin
                checks++; if (dmem_addr !== 20'h10 || dmem_we !== 1'b0) begin
                    errors++; $display("FAIL load_addr: got %h we=%b want 10 0", dmem_addr, dmem_we); end
            end
            next_edge();
            if (c < 4) begin
                checks++; if (wb_regWrite !== 1'b0) begin
                    errors++; $display("FAIL load_bubble c%0d: got %b want 0", c, wb_regWrite); end
            end
        end
        checks++; if (stalls != 4) begin errors++; $display("FAIL load_stalls: got %0d want 4", stalls); end
        checks++; if (wb_regWrite !== 1'b1 || wb_rd !== 5'd9 || wb_write_data !== 32'hDEADBEEF) begin
            errors++; $display("FAIL load_wb: got %b %0d %h want 1 9 deadbeef", wb_regWrite, wb_rd, wb_write_data); end
        checks++; if (mem_error !== 1'b0) begin errors++; $display("FAIL load_err: got %b want 0", mem_error); end
        idle_inputs();
    endtask

    task automatic test_store;
        int stalls = 0;
        mem_store = 1'b1; mem_regWrite = 1'b1; mem_rd = 5'd7;
        mem_ALU_result = 32'h8; mem_store_data = 32'hA5;
        for (int c = 0; c < 3; c++) begin
            dmem_gnt = (c == 2);
            @(negedge clock);
            if (mem_stall === 1'b1) stalls++;
            checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 20'h2 || dmem_wdata !== 32'hA5) begin
                errors++; $display("FAIL store_hold c%0d: got req=%b we=%b addr=%h wdata=%h want 1 1 2 a5",
                                   c, dmem_req, dmem_we, dmem_addr, dmem_wdata); end
            next_edge();
        end
        checks++; if (stalls != 2) begin errors++; $display("FAIL store_stalls: got %0d want 2", stalls); end
        checks++; if (wb_regWrite !== 1'b0 || mem_write !== 1'b0) begin
            errors++; $display("FAIL store_wb: got %b %b want 0 0", wb_regWrite, mem_write); end
        idle_inputs();
    endtask

    task automatic test_timeout;
        do_reset();
        mem_load = 1'b1; mem_regWrite = 1'b1; mem_rd = 5'd3; mem_ALU_result = 32'h20;
        dmem_rdata = 32'h55;
        for (int c = 0; c < 4; c++) begin
            dmem_gnt = (c == 0);
            @(negedge clock);
            checks++; if (mem_stall_t !== (c < 3)) begin
                errors++; $display("FAIL timeout_stall c%0d: got %b want %b", c, mem_stall_t, (c < 3)); end
            next_edge();
            if (c == 2) begin
                checks++; if (mem_error_t !== 1'b0) begin
                    errors++; $display("FAIL timeout_early_err: got %b want 0", mem_error_t); end
            end
        end
        checks++; if (wb_regWrite_t !== 1'b1 || wb_rd_t !== 5'd3 || wb_write_data_t !== 32'h0) begin
            errors++; $display("FAIL timeout_wb: got %b %0d %h want 1 3 0", wb_regWrite_t, wb_rd_t, wb_write_data_t); end
        checks++; if (mem_error_t !== 1'b1) begin errors++; $display("FAIL timeout_err: got %b want 1", mem_error_t); end
        idle_inputs();
        for (int c = 0; c < 3; c++) next_edge();
        checks++; if (mem_error_t !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %b want 1", mem_error_t); end
        do_reset();
        checks++; if (mem_error_t !== 1'b0) begin errors++; $display("FAIL timeout_clear: got %b want 0", mem_error_t); end
    endtask

    task automatic test_rd_zero;
        mem_load = 1'b1; mem_regWrite = 1'b1; mem_rd = 5'd0; mem_ALU_result = 32'h10;
        dmem_gnt = 1'b1;
        next_edge();
        dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'hFF;
        next_edge();
        checks++; if (wb_regWrite !== 1'b0 || mem_write !== 1'b0 || wb_write_data !== 32'hFF) begin
            errors++; $display("FAIL rd0_wb: got %b %b %h want 0 0 ff", wb_regWrite, mem_write, wb_write_data); end
        idle_inputs();
    endtask

    task automatic test_errors;
        do_reset();
        mem_load = 1'b1; mem_regWrite = 1'b1; mem_rd = 5'd4; mem_ALU_result = 32'h46;
        dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h99;
        @(negedge clock);
        checks++; if (dmem_addr !== 20'h11 || mem_stall !== 1'b1) begin
            errors++; $display("FAIL misalign_idle: got addr=%h stall=%b want 11 1", dmem_addr, mem_stall); end
        next_edge();
        dmem_gnt = 1'b0; dmem_rdata = 32'hCAFE;
        next_edge();
        checks++; if (wb_write_data !== 32'hCAFE || mem_error !== 1'b1) begin
            errors++; $display("FAIL misalign_wb: got %h err=%b want cafe 1", wb_write_data, mem_error); end
        do_reset();
        mem_load = 1'b1; mem_store = 1'b1; mem_regWrite = 1'b1; mem_rd = 5'd6;
        mem_ALU_result = 32'h30; mem_store_data = 32'h1; dmem_gnt = 1'b1;
        @(negedge clock);
        checks++; if (dmem_we !== 1'b0 || mem_stall !== 1'b1) begin
            errors++; $display("FAIL both_we: got we=%b stall=%b want 0 1", dmem_we, mem_stall); end
        next_edge();
        dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h77;
        next_edge();
        checks++; if (wb_write_data !== 32'h77 || wb_regWrite !== 1'b1 || mem_error !== 1'b1) begin
            errors++; $display("FAIL both_wb: got %h %b err=%b want 77 1 1", wb_write_data, wb_regWrite, mem_error); end
        idle_inputs();
    endtask

    task automatic test_reset_mid;
        mem_load = 1'b1; mem_regWrite = 1'b1; mem_rd = 5'd8; mem_ALU_result = 32'h50;
        dmem_gnt = 1'b1;
        next_edge();
        dmem_gnt = 1'b0;
        next_edge();
        reset = 1'b1;
        next_edge();
        reset = 1'b0;
        checks++; if (wb_regWrite !== 1'b0 || wb_write_data !== 32'h0 || mem_error !== 1'b0) begin
            errors++; $display("FAIL midreset_out: got %b %h err=%b want 0 0 0", wb_regWrite, wb_write_data, mem_error); end
        dmem_rvalid = 1'b1; dmem_rdata = 32'hBAD;
        @(negedge clock);
        checks++; if (mem_stall !== 1'b1 || dmem_req !== 1'b1) begin
            errors++; $display("FAIL midreset_rvalid: got stall=%b req=%b want 1 1", mem_stall, dmem_req); end
        next_edge();
        checks++; if (wb_regWrite !== 1'b0 || wb_write_data !== 32'h0 || mem_error !== 1'b0) begin
            errors++; $display("FAIL midreset_capture: got %b %h err=%b want 0 0 0", wb_regWrite, wb_write_data, mem_error); end
        idle_inputs();
        next_edge();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        next_edge();
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_timeout();
        test_rd_zero();
        test_errors();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
